// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, receive-buffer entry type and receive-path states
package uart_pkg;
    localparam int WIDTH_SIZE = 8;
    typedef struct packed {
        logic                  err;
        logic [WIDTH_SIZE-1:0] data;
    } rx_entry_t;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_type;
endpackage

// File: rtl/rx_fifo_mem.sv
// rx_fifo_mem: unreset entry storage with synchronous write and asynchronous read
module rx_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  rx_entry_t       wdata,
    input  logic [AW-1:0]   raddr,
    output rx_entry_t       rdata
);
    rx_entry_t mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/rx_fifo.sv
// rx_fifo: first-word-fall-through receive buffer with sticky overflow and saturating parity-error count
module rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH_SIZE = uart_pkg::WIDTH_SIZE,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic                     in_err,
    input  logic [WIDTH_SIZE-1:0]    in_data,
    input  logic                     rd_en,
    output logic                     out_valid,
    output logic [WIDTH_SIZE-1:0]    out_data,
    output logic                     out_err,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     overflow,
    input  logic                     ovf_clr,
    output logic [7:0]               err_count,
    input  logic                     err_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AF = AF_LEVEL[AW:0];
    logic [AW:0] wr_ptr, rd_ptr;
    logic push, pop, drop;
    rx_entry_t wr_entry, rd_entry;
    assign empty       = wr_ptr == rd_ptr;
    assign full        = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count       = wr_ptr - rd_ptr;
    assign almost_full = count >= AF;
    assign pop         = rd_en && !empty;
    // a pop on a full FIFO frees the slot the incoming word takes
    assign push        = in_valid && (!full || pop);
    assign drop        = in_valid && full && !pop;
    assign wr_entry    = '{err: in_err, data: in_data};
    assign out_valid   = !empty;
    assign out_data    = empty ? '0 : rd_entry.data;
    assign out_err     = empty ? 1'b0 : rd_entry.err;
    rx_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_entry),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_entry)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            err_count <= '0;
        end else begin
            wr_ptr    <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr    <= pop ? rd_ptr + 1'b1 : rd_ptr;
            overflow  <= drop ? 1'b1 : ovf_clr ? 1'b0 : overflow;
            err_count <= err_clr ? 8'd0 :
                         (in_valid && in_err && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
        end
    end
endmodule

// File: tb/tb_rx_fifo.sv
// tb_rx_fifo: directed vector table, corner sequences and randomized traffic against a queue model
module tb_rx_fifo;
    localparam int DEPTH = 8;
    localparam int AFL   = 6;

    logic       clk = 0;
    logic       reset = 0;
    logic       in_valid = 0, in_err = 0, rd_en = 0, ovf_clr = 0, err_clr = 0;
    logic [7:0] in_data = 0;
    logic       out_valid, out_err, full, empty, almost_full, overflow;
    logic [7:0] out_data, err_count;
    logic [3:0] count;

    rx_fifo #(.WIDTH_SIZE(8), .DEPTH(DEPTH), .AF_LEVEL(AFL)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_err(in_err), .in_data(in_data),
        .rd_en(rd_en), .out_valid(out_valid), .out_data(out_data), .out_err(out_err),
        .count(count), .full(full), .empty(empty), .almost_full(almost_full),
        .overflow(overflow), .ovf_clr(ovf_clr), .err_count(err_count), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic err; logic [7:0] data; } ent_t;
    ent_t q[$];
    bit   m_ovf;
    int   m_errc;
    int   n_chk = 0, n_fail = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference: queue semantics straight from the push/pop/overflow/error rules
    task automatic model_edge();
        bit pop;
        pop = rd_en && q.size() > 0;
        if (err_clr) m_errc = 0;
        else if (in_valid && in_err && m_errc < 255) m_errc++;
        if (in_valid && q.size() == DEPTH && !pop) m_ovf = 1;
        else if (ovf_clr) m_ovf = 0;
        if (pop) void'(q.pop_front());
        if (in_valid && q.size() < DEPTH) q.push_back({in_err, in_data});
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 0;
        m_errc = 0;
    endtask

    task automatic check_model();
        int n;
        n = q.size();
        chk("out_valid", 32'(out_valid), 32'(n > 0));
        chk("out_data", 32'(out_data), n > 0 ? 32'(q[0].data) : 32'd0);
        chk("out_err", 32'(out_err), n > 0 ? 32'(q[0].err) : 32'd0);
        chk("count", 32'(count), 32'(n));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("almost_full", 32'(almost_full), 32'(n >= AFL));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("err_count", 32'(err_count), 32'(m_errc));
    endtask

    task automatic cyc(bit iv, bit ie, bit [7:0] d, bit re, bit oc, bit ec);
        in_valid = iv; in_err = ie; in_data = d; rd_en = re; ovf_clr = oc; err_clr = ec;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    typedef struct {
        bit       iv;
        bit [7:0] d;
        bit       re;
        bit       oc;
        int       e_cnt;
        bit       e_valid;
        bit [7:0] e_data;
        bit       e_ovf;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t v(bit iv, bit [7:0] d, bit re, bit oc, int c, bit vl, bit [7:0] hd, bit ov);
        vec_t r;
        r.iv = iv; r.d = d; r.re = re; r.oc = oc;
        r.e_cnt = c; r.e_valid = vl; r.e_data = hd; r.e_ovf = ov;
        return r;
    endfunction

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model();
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_out_data", 32'(out_data), 32'd0);
        reset = 1;

        // directed table: single word, fill, overflow, clear, full push+pop, drain
        tbl.push_back(v(1, 8'hA5, 0, 0, 1, 1, 8'hA5, 0));
        tbl.push_back(v(0, 8'h00, 1, 0, 0, 0, 8'h00, 0));
        for (int i = 1; i <= 8; i++) tbl.push_back(v(1, 8'(i), 0, 0, i, 1, 8'h01, 0));
        tbl.push_back(v(1, 8'h09, 0, 0, 8, 1, 8'h01, 1));
        tbl.push_back(v(0, 8'h00, 0, 1, 8, 1, 8'h01, 0));
        tbl.push_back(v(1, 8'h55, 1, 0, 8, 1, 8'h02, 0));
        for (int i = 3; i <= 8; i++) tbl.push_back(v(0, 8'h00, 1, 0, 10 - i, 1, 8'(i), 0));
        tbl.push_back(v(0, 8'h00, 1, 0, 1, 1, 8'h55, 0));
        tbl.push_back(v(0, 8'h00, 1, 0, 0, 0, 8'h00, 0));
        foreach (tbl[i]) begin
            cyc(tbl[i].iv, 0, tbl[i].d, tbl[i].re, tbl[i].oc, 0);
            chk("tbl_count", 32'(count), 32'(tbl[i].e_cnt));
            chk("tbl_valid", 32'(out_valid), 32'(tbl[i].e_valid));
            chk("tbl_data", 32'(out_data), 32'(tbl[i].e_data));
            chk("tbl_ovf", 32'(overflow), 32'(tbl[i].e_ovf));
        end

        // parity-error flags, saturation and clear priority
        cyc(1, 1, 8'h11, 0, 0, 0);
        cyc(1, 0, 8'h22, 0, 0, 0);
        cyc(1, 1, 8'h33, 0, 0, 0);
        chk("err_count_2", 32'(err_count), 32'd2);
        for (int i = 0; i < 3; i++) begin
            chk("err_seq", 32'(out_err), 32'(i != 1));
            cyc(0, 0, 8'h00, 1, 0, 0);
        end
        for (int i = 0; i < 260; i++) cyc(1, 1, 8'($urandom), 1, 0, 0);
        chk("err_sat", 32'(err_count), 32'd255);
        cyc(1, 1, 8'h77, 0, 0, 1);
        chk("err_clr_wins", 32'(err_count), 32'd0);
        while (q.size() > 0) cyc(0, 0, 8'h00, 1, 0, 0);

        // asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) cyc(1, 0, 8'(8'hC0 + i), 0, 0, 0);
        cyc(0, 0, 8'h00, 0, 0, 0);
        #3 reset = 0;
        #1;
        model_reset();
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #2 reset = 1;
        check_model();
        cyc(1, 0, 8'h3C, 0, 0, 0);
        chk("arst_first", 32'(out_data), 32'h3C);
        cyc(0, 0, 8'h00, 1, 0, 0);

        // pointer wrap with one-deep occupancy
        for (int i = 0; i < 20; i++) begin
            cyc(1, 0, 8'(8'h40 + i), 0, 0, 0);
            chk("wrap_data", 32'(out_data), 32'(8'h40 + i));
            chk("wrap_count", 32'(count), 32'd1);
            cyc(0, 0, 8'h00, 1, 0, 0);
        end

        // randomized traffic
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 99) < 55, $urandom_range(0, 3) == 0, 8'($urandom),
                $urandom_range(0, 99) < 45, $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);

        in_valid = 0; rd_en = 0; ovf_clr = 0; err_clr = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rx_fifo.md
Name: rx_fifo

Overview:
Receive buffer directly downstream of the UART receive path. It captures each received word together with its parity-error flag on the receiver's one-cycle valid pulse. Words are held in a first-word-fall-through FIFO and presented to the host/bus side through a valid/read-enable handshake. It also provides a sticky overflow flag and a saturating parity-error counter.

Parameters:
WIDTH_SIZE, 8, data word width; must match the receive path.
DEPTH, 8, number of entries; power of two, >= 2.
AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL; range 1..DEPTH.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
in_valid  input  1  word-available pulse from the receive path; each high cycle is one word
in_err  input  1  parity error flag for the word; sampled only with in_valid
in_data  input  WIDTH_SIZE  received word; sampled only with in_valid
rd_en  input  1  consumer pops the head entry this cycle
out_valid  output  1  head entry present (= !empty)
out_data  output  WIDTH_SIZE  head entry data; 0 when empty
out_err  output  1  head entry parity flag; 0 when empty
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
overflow  output  1  sticky: a word was dropped because the FIFO was full
ovf_clr  input  1  synchronous clear of overflow
err_count  output  8  saturating count of words received with in_err=1
err_clr  input  1  synchronous clear of err_count

Behaviour:
- Reset (reset=0, asynchronous): write and read pointers = 0; count = 0; overflow = 0; err_count = 0. Outputs are therefore empty=1, full=0, almost_full=0, out_valid=0, out_data=0, out_err=0. Memory contents are not cleared. Reset mid-stream discards all stored words.
- Pointers are $clog2(DEPTH)+1 bits wide; the extra MSB is the wrap bit. empty = pointers equal. full = low bits equal and MSBs differ. Increments wrap naturally modulo 2*DEPTH.
- Push: in_valid=1 and (!full or pop this cycle). {in_err, in_data} is written at wr_ptr, and wr_ptr increments at the clock edge.
- Pop: rd_en=1 and !empty. rd_ptr increments. A pop while empty is ignored, with no pointer change and no error.
- Fall-through: out_data/out_err reflect mem[rd_ptr] combinationally from registered storage. A word pushed at edge N is visible on out_* after edge N, with out_valid=1 in cycle N+1.
- Simultaneous push and pop:
  - When not empty: both happen and count is unchanged.
  - When full: both happen (the pop frees the slot) and no overflow is flagged.
  - When empty: only the push happens; no bypass, so out_valid rises the next cycle.
- Overflow: in_valid=1, full=1 and no pop. The word is dropped and overflow <= 1. overflow stays set until ovf_clr. If ovf_clr and a new drop coincide, the set wins.
- err_count:
  - Increments on every in_valid with in_err=1, whether the word was stored or dropped.
  - Saturates at 255.
  - err_clr has priority over a simultaneous increment (result 0).
- count, full, empty and almost_full are registered or derived from registered pointers only; there is no combinational path from in_valid or rd_en to these flags.
- in_valid is normally a single-cycle pulse with gaps of at least one frame. Back-to-back in_valid cycles must still be accepted at one word per cycle.

Decomposition:
- Shared package uart_pkg:
  - WIDTH_SIZE default constant.
  - rx_entry_t struct {logic err; logic [WIDTH_SIZE-1:0] data}.
  - Reuse the package's state_type enum for receive-path states; rx_fifo does not need it.
- One sub-module, rx_fifo_mem:
  - DEPTH x rx_entry_t register array.
  - Synchronous write port and asynchronous read port.
  - No reset on the storage.
- Pointer, flag and counter logic stays in rx_fifo.

Test Plan:
- Reset, then push 0xA5 (in_err=0) -> next cycle out_valid=1, out_data=0xA5, out_err=0, count=1; pop -> empty=1, out_data=0.
- Push 8 words 0x01..0x08 with no reads -> full=1, almost_full asserted from count=6; 9th push 0x09 -> dropped, overflow=1, count=8. Pops return 0x01..0x08 in order; ovf_clr -> overflow=0.
- FIFO full, same cycle in_valid=1 (0x55) and rd_en=1 -> count stays 8, overflow=0, 0x55 emerges as 8th read.
- Push 3 words with in_err=1,0,1 -> err_count=2 and out_err sequence 1,0,1. Force 260 error words with continuous popping -> err_count=255. err_clr with a simultaneous error word -> err_count=0.
- Fill 5 entries, assert reset low asynchronously mid-cycle -> immediately count=0, empty=1, out_valid=0. After release, the next push 0x3C is the first word read.
- Pointer wrap: 20 interleaved push/pop pairs of an incrementing pattern -> data order preserved across both wraps, count never exceeds 1.
